// File: rtl/pipe_seq_if.sv
// Bundle of the sequencer's stage, hazard, halt and counter signals.
// The core side drives the fetch/hazard/halt inputs; the sequencer drives the rest.
interface pipe_seq_if #(
    parameter int unsigned CNT_W = 32
);
    logic [31:0]      instr_f;
    logic             stall_in;
    logic             br_taken_x;
    logic             halt_req;
    logic             go;

    logic [31:0]      instr_d;
    logic [31:0]      instr_x;
    logic [31:0]      instr_m;
    logic [31:0]      instr_w;
    logic             pc_en;
    logic             halted;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] retire_cnt;

    // Core side: supplies fetched instruction and control requests.
    modport master (
        output instr_f, stall_in, br_taken_x, halt_req, go,
        input  instr_d, instr_x, instr_m, instr_w, pc_en, halted,
        input  cycle_cnt, stall_cnt, flush_cnt, retire_cnt
    );

    // Sequencer side.
    modport slave (
        input  instr_f, stall_in, br_taken_x, halt_req, go,
        output instr_d, instr_x, instr_m, instr_w, pc_en, halted,
        output cycle_cnt, stall_cnt, flush_cnt, retire_cnt
    );
endinterface

// File: rtl/pipe_seq_ctrl.sv
// Pipeline register sequencer for the 5-stage RV32I core.
// Holds the D/X/M/W instruction registers, applies stall bubbles and branch flushes,
// drives the PC load enable, runs a RUN/DRAIN/HALTED halt machine and keeps
// free-running performance counters.
module pipe_seq_ctrl #(
    parameter logic [31:0] NOP   = 32'h0000_0013,
    parameter int unsigned CNT_W = 32
) (
    input  logic           clk,
    input  logic           reset,
    pipe_seq_if.slave      bus
);

    typedef enum logic [1:0] {
        StRun    = 2'd0,
        StDrain  = 2'd1,
        StHalted = 2'd2
    } state_e;

    // Per-cycle pipeline action, resolved from state and hazard inputs.
    typedef enum logic [1:0] {
        ActAdvance = 2'd0,
        ActStall   = 2'd1,
        ActFlush   = 2'd2,
        ActHold    = 2'd3
    } action_e;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e           state_q, state_d;
    action_e          action;
    logic             pc_en;
    logic             load_fetch;
    logic             halted_q;

    logic [31:0]      instr_d_q, instr_x_q, instr_m_q, instr_w_q;
    logic [CNT_W-1:0] cycle_cnt_q, stall_cnt_q, flush_cnt_q, retire_cnt_q;

    logic             upper_empty;

    // D, X and M all hold bubbles: only W can still be retiring.
    assign upper_empty = (instr_d_q == NOP) && (instr_x_q == NOP) && (instr_m_q == NOP);

    // State register; halted is registered alongside so it is not a comb output.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StRun;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= (state_d == StHalted);
        end
    end

    // Next-state logic for the halt/drain machine.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StRun: begin
                if (bus.halt_req) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (upper_empty) begin
                    state_d = StHalted;
                end
            end
            StHalted: begin
                if (bus.go) begin
                    state_d = StRun;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Output decode: pipeline action and PC enable; flush beats stall beats advance.
    always_comb begin
        action     = ActAdvance;
        pc_en      = 1'b0;
        load_fetch = 1'b0;
        unique case (state_q)
            StRun, StDrain: begin
                if (bus.br_taken_x) begin
                    action = ActFlush;
                    pc_en  = 1'b1;  // PC loads the branch target
                end else if (bus.stall_in) begin
                    action = ActStall;
                    pc_en  = 1'b0;
                end else begin
                    action     = ActAdvance;
                    // PC frozen while draining so the dropped fetch is refetched on resume.
                    pc_en      = (state_q == StRun);
                    load_fetch = (state_q == StRun);
                end
            end
            StHalted: begin
                action = ActHold;
                pc_en  = 1'b0;
            end
            default: begin
                action = ActHold;
                pc_en  = 1'b0;
            end
        endcase
    end

    // Stage registers: M and W always shift; D and X depend on the action.
    always_ff @(posedge clk) begin
        if (reset) begin
            instr_d_q <= NOP;
            instr_x_q <= NOP;
            instr_m_q <= NOP;
            instr_w_q <= NOP;
        end else begin
            instr_w_q <= instr_m_q;
            instr_m_q <= instr_x_q;
            unique case (action)
                ActFlush: begin
                    instr_x_q <= NOP;
                    instr_d_q <= NOP;
                end
                ActStall: begin
                    instr_x_q <= NOP;  // bubble into X, D held
                end
                ActAdvance: begin
                    instr_x_q <= instr_d_q;
                    instr_d_q <= load_fetch ? bus.instr_f : NOP;
                end
                default: begin
                    instr_x_q <= instr_d_q;
                    instr_d_q <= NOP;
                end
            endcase
        end
    end

    // Performance counters; wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q  <= '0;
            stall_cnt_q  <= '0;
            flush_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            if (state_q != StHalted) begin
                cycle_cnt_q <= cycle_cnt_q + CntOne;
            end
            if (action == ActStall) begin
                stall_cnt_q <= stall_cnt_q + CntOne;
            end
            if (action == ActFlush) begin
                flush_cnt_q <= flush_cnt_q + CntOne;
            end
            if (instr_w_q != NOP) begin
                retire_cnt_q <= retire_cnt_q + CntOne;
            end
        end
    end

    assign bus.instr_d    = instr_d_q;
    assign bus.instr_x    = instr_x_q;
    assign bus.instr_m    = instr_m_q;
    assign bus.instr_w    = instr_w_q;
    assign bus.pc_en      = pc_en;
    assign bus.halted     = halted_q;
    assign bus.cycle_cnt  = cycle_cnt_q;
    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
    assign bus.retire_cnt = retire_cnt_q;

    // Sanity properties on internal state.
    a_state_legal: assert property (@(posedge clk) disable iff (reset)
        state_q != 2'b11);
    a_halted_no_pc: assert property (@(posedge clk) disable iff (reset)
        (state_q == StHalted) |-> !pc_en);
    a_halted_flag: assert property (@(posedge clk) disable iff (reset)
        halted_q == (state_q == StHalted));

endmodule

// File: tb/tb_pipe_seq_ctrl.sv
// Scoreboard bench for pipe_seq_ctrl: a 32-bit-counter and a 4-bit-counter build share
// stimulus; a stage-list reference model queues expected results for a separate monitor.
module tb_pipe_seq_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int ModeRun    = 0;
    localparam int ModeDrain  = 1;
    localparam int ModeHalted = 2;

    typedef struct {
        logic [31:0] stage [4];  // 0=D 1=X 2=M 3=W
        logic        halted;
        logic [31:0] cyc;
        logic [31:0] stl;
        logic [31:0] fls;
        logic [31:0] ret;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr_f;
    logic        stall_in, br_taken_x, halt_req, go;

    always #5 clk = ~clk;

    pipe_seq_if #(.CNT_W(32)) bus32 ();
    pipe_seq_if #(.CNT_W(4))  bus4 ();

    assign bus32.instr_f    = instr_f;
    assign bus32.stall_in   = stall_in;
    assign bus32.br_taken_x = br_taken_x;
    assign bus32.halt_req   = halt_req;
    assign bus32.go         = go;
    assign bus4.instr_f     = instr_f;
    assign bus4.stall_in    = stall_in;
    assign bus4.br_taken_x  = br_taken_x;
    assign bus4.halt_req    = halt_req;
    assign bus4.go          = go;

    pipe_seq_ctrl #(.NOP(NOP), .CNT_W(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    pipe_seq_ctrl #(.NOP(NOP), .CNT_W(4)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4.slave)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic pc_q  [$];
    exp_t reg_q [$];

    // Reference model: pipeline as a list of four stage slots plus mode and counters.
    logic [31:0] m_stage [4];
    int          m_mode;
    logic [31:0] m_cyc, m_stl, m_fls, m_ret;

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_stage[i] = NOP;
        m_mode = ModeRun;
        m_cyc = 0; m_stl = 0; m_fls = 0; m_ret = 0;
    endtask

    function automatic logic model_pc(input logic st, input logic br);
        if (m_mode == ModeHalted) return 1'b0;
        if (br) return 1'b1;
        if (st) return 1'b0;
        return (m_mode == ModeRun);
    endfunction

    task automatic model_step(input logic rst, input logic [31:0] f, input logic st,
                              input logic br, input logic hr, input logic g);
        logic [31:0] nxt [4];
        int          nmode;
        bit          empty;
        if (rst) begin
            model_reset();
            return;
        end
        empty = 1'b1;
        for (int i = 0; i < 3; i++) if (m_stage[i] != NOP) empty = 1'b0;
        if (m_stage[3] != NOP) m_ret++;
        if (m_mode != ModeHalted) m_cyc++;
        // Older instructions always move one slot toward W.
        nxt[3] = m_stage[2];
        nxt[2] = m_stage[1];
        if (m_mode != ModeHalted && br) begin
            nxt[1] = NOP; nxt[0] = NOP; m_fls++;
        end else if (m_mode != ModeHalted && st) begin
            nxt[1] = NOP; nxt[0] = m_stage[0]; m_stl++;
        end else begin
            nxt[1] = m_stage[0];
            nxt[0] = (m_mode == ModeRun) ? f : NOP;
        end
        case (m_mode)
            ModeRun:   nmode = hr ? ModeDrain : ModeRun;
            ModeDrain: nmode = empty ? ModeHalted : ModeDrain;
            default:   nmode = g ? ModeRun : ModeHalted;
        endcase
        for (int i = 0; i < 4; i++) m_stage[i] = nxt[i];
        m_mode = nmode;
    endtask

    // One clock of stimulus: drive at negedge, queue the expected responses.
    task automatic cyc(input logic rst, input logic [31:0] f, input logic st,
                       input logic br, input logic hr, input logic g);
        exp_t e;
        @(negedge clk);
        reset = rst; instr_f = f; stall_in = st; br_taken_x = br; halt_req = hr; go = g;
        pc_q.push_back(model_pc(st, br));
        model_step(rst, f, st, br, hr, g);
        for (int i = 0; i < 4; i++) e.stage[i] = m_stage[i];
        e.halted = (m_mode == ModeHalted);
        e.cyc = m_cyc; e.stl = m_stl; e.fls = m_fls; e.ret = m_ret;
        reg_q.push_back(e);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    // Monitor: pc_en mid-cycle, registered outputs just after each rising edge.
    initial begin
        exp_t e;
        logic p;
        forever begin
            @(negedge clk);
            #2;
            if (pc_q.size() > 0) begin
                p = pc_q.pop_front();
                check("pc_en", {31'b0, bus32.pc_en}, {31'b0, p});
                check("pc_en_w4", {31'b0, bus4.pc_en}, {31'b0, p});
            end
            @(posedge clk);
            #1;
            if (reg_q.size() > 0) begin
                e = reg_q.pop_front();
                check("instr_d", bus32.instr_d, e.stage[0]);
                check("instr_x", bus32.instr_x, e.stage[1]);
                check("instr_m", bus32.instr_m, e.stage[2]);
                check("instr_w", bus32.instr_w, e.stage[3]);
                check("halted", {31'b0, bus32.halted}, {31'b0, e.halted});
                check("cycle_cnt", bus32.cycle_cnt, e.cyc);
                check("stall_cnt", bus32.stall_cnt, e.stl);
                check("flush_cnt", bus32.flush_cnt, e.fls);
                check("retire_cnt", bus32.retire_cnt, e.ret);
                check("instr_w_w4", bus4.instr_w, e.stage[3]);
                check("cycle_cnt_w4", {28'b0, bus4.cycle_cnt}, e.cyc & 32'hF);
                check("stall_cnt_w4", {28'b0, bus4.stall_cnt}, e.stl & 32'hF);
                check("flush_cnt_w4", {28'b0, bus4.flush_cnt}, e.fls & 32'hF);
                check("retire_cnt_w4", {28'b0, bus4.retire_cnt}, e.ret & 32'hF);
            end
        end
    end

    function automatic logic [31:0] rnd_instr();
        logic [31:0] v;
        v = $urandom();
        if (v == NOP || ($urandom_range(0, 7) == 0)) v = NOP;
        return v;
    endfunction

    initial begin
        reset = 1'b1; instr_f = NOP; stall_in = 1'b0; br_taken_x = 1'b0;
        halt_req = 1'b0; go = 1'b0;
        // Unchecked power-on reset so the DUT state is known before checking begins.
        repeat (2) @(negedge clk);
        model_reset();

        // Checked reset, then A,B,C,D with no hazards: A reaches W four edges in.
        cyc(1, NOP, 0, 0, 0, 0);
        cyc(0, 32'hA000_0001, 0, 0, 0, 0);
        cyc(0, 32'hB000_0002, 0, 0, 0, 0);
        cyc(0, 32'hC000_0003, 0, 0, 0, 0);
        cyc(0, 32'hD000_0004, 0, 0, 0, 0);
        // Two stall cycles, then flush with stall also asserted.
        cyc(0, 32'hE000_0005, 1, 0, 0, 0);
        cyc(0, 32'hE000_0005, 1, 0, 0, 0);
        cyc(0, 32'hE000_0005, 0, 0, 0, 0);
        cyc(0, 32'hF000_0006, 1, 1, 0, 0);
        cyc(0, 32'h1000_0007, 0, 0, 0, 0);
        cyc(0, 32'h2000_0008, 0, 0, 0, 0);
        cyc(0, 32'h3000_0009, 0, 0, 0, 0);
        // Halt pulse with D/X/M full, sit halted, go ignored-halt_req check, resume.
        cyc(0, 32'h4000_000A, 0, 0, 1, 0);
        for (int i = 0; i < 6; i++) cyc(0, rnd_instr(), 0, 0, 1, 0);
        cyc(0, 32'h4000_000A, 0, 0, 1, 1);
        // Long run without hazards so the 4-bit counters wrap 15 -> 0.
        for (int i = 0; i < 24; i++) cyc(0, 32'h5000_0000 + i, 0, 0, 0, 0);
        // Reset while draining.
        cyc(0, 32'h6000_0001, 0, 0, 1, 0);
        cyc(0, 32'h6000_0002, 0, 0, 0, 0);
        cyc(1, 32'h6000_0003, 0, 0, 0, 0);
        cyc(0, 32'h7000_0001, 0, 0, 0, 0);

        // Randomized traffic including halts, resumes and occasional resets.
        for (int i = 0; i < 400; i++) begin
            cyc(($urandom_range(0, 99) == 0),
                rnd_instr(),
                ($urandom_range(0, 4) == 0),
                ($urandom_range(0, 7) == 0),
                ($urandom_range(0, 19) == 0),
                ($urandom_range(0, 3) == 0));
        end

        repeat (3) @(posedge clk);
        #2;
        n_checks++;
        if (pc_q.size() != 0 || reg_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain_queues: got %0d/%0d pending expected 0/0",
                     pc_q.size(), reg_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
